cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
Execute-stage consumer of the ALU's 4-bit NZCV flag bus in the pipelined ARM core. It holds the architectural flags register and updates it per FlagWrite group. It evaluates the 4-bit ARM condition field against the current flags and gates PCSrc/RegWrite/MemWrite. It also registers the gated controls into the Memory stage, honouring stall and flush.

Parameters:
CNT_W, 32, width of the optional statistics counters
RESET_FLAGS, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
StallE  in  1  hold E/M boundary: no flag update, M-stage registers hold
FlushE  in  1  instruction in E is a bubble
CondE  in  4  ARM condition field of the instruction in E
FlagWriteE  in  2  [1]=update N,Z; [0]=update C,V
AluFlags  in  4  {N,Z,C,V} from ALU, same cycle
PCSrcE  in  1  ungated branch/PC-write request
RegWriteE  in  1  ungated register write
MemWriteE  in  1  ungated memory write
CondExE  out  1  condition passed and not flushed (combinational)
PCSrcGatedE  out  1  PCSrcE & CondExE (combinational)
RegWriteM  out  1  registered RegWriteE & CondExE
MemWriteM  out  1  registered MemWriteE & CondExE
Flags  out  4  architectural {N,Z,C,V}; also carry-in source for the ALU

Behaviour:
- Reset (sync, at clk edge while reset=1): Flags=RESET_FLAGS, RegWriteM=0, MemWriteM=0, counters=0. Reset overrides stall and flush.
- Condition evaluation is combinational on registered Flags, with zero latency:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 evaluates to 0 (never).
- CondExE = condpass & ~FlushE.
- Flag update at the clk edge when ~reset & ~StallE & CondExE:
  - FlagWriteE[1] loads N,Z from AluFlags[3:2].
  - FlagWriteE[0] loads C,V from AluFlags[1:0].
  - Each group is independent; a group that is not written holds its value.
- A failed condition never writes flags, even with FlagWriteE=11.
- The new flags are visible to the next instruction in E (one-cycle latency). There is no same-cycle bypass.
- M-stage registers:
  - StallE=1: hold.
  - Else FlushE=1: load 0 (bubble).
  - Else: load the gated values.
  - Stall has priority over flush for the M registers; flush still forces CondExE=0 combinationally.
- PCSrcGatedE is never registered; the hazard unit consumes it in the same cycle.
- No X propagation: every case arm is defined, with default CondExE=0.

Optional Feature:
COND_STATS_EN
- Defined:
  - Adds output ports ExecCount and SkipCount, each CNT_W bits.
  - Each cycle with ~StallE & ~FlushE & ~reset, exactly one counter increments: ExecCount if condpass, else SkipCount.
  - Both counters wrap modulo 2^CNT_W.
  - Both clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cond_pkg holds:
  - enum cond_e with the 16 condition codes (EQ..AL, NV);
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - FlagWrite bit constants FW_NZ=1, FW_CV=0.
- One combinational sub-module, cond_check (inputs CondE and Flags, output condpass), reusable by a future predicated-issue stage.
- The flag register, M registers and counters stay in cond_unit.

Test Plan:
1. Assert reset 1 cycle -> Flags=0000, RegWriteM=0, MemWriteM=0. Then CondE=0000, RegWriteE=1 -> CondExE=0; next cycle RegWriteM=0.
2. Flags=0000, AluFlags=0100, FlagWriteE=11, CondE=1110 -> next cycle Flags=0100. Then CondE=0000, PCSrcE=1 -> CondExE=1, PCSrcGatedE=1 in the same cycle.
3. Flags=0100, AluFlags=1011, FlagWriteE=10 -> Flags=1000. Then AluFlags=0011, FlagWriteE=01 -> Flags=1011.
4. Flags=1001: GE=1, LT=0, GT=1, LE=0. Flags=0110: HI=0, LS=1. CondE=1111 -> CondExE=0.
5. StallE=1 with FlagWriteE=11, AluFlags=1111 -> Flags unchanged and RegWriteM holds its prior 1. Then FlushE=1 with RegWriteE=1, CondE=1110 -> CondExE=0, next RegWriteM=0, Flags unchanged.
6. Flags=1111, with ExecCount=5 under COND_STATS_EN; assert reset while StallE=1 -> next edge Flags=0000, counters=0. Condition-failing instruction with FlagWriteE=11 -> no flag change, SkipCount+1.

Source files
------------

// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_pkg
// Purpose  : Shared condition codes and flag/FlagWrite bit positions for the
//            execute-stage condition unit.
// Revision : 1.0 - initial release
// ============================================================================
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module   : cond_check
// Purpose  : Purely combinational ARM condition-field evaluator against NZCV.
// Revision : 1.0 - initial release
// ============================================================================
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] Flags,
    output logic       condpass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        condpass = 1'b0;
        case (cond_e'(CondE))
            EQ:      condpass = z;
            NE:      condpass = ~z;
            CS:      condpass = c;
            CC:      condpass = ~c;
            MI:      condpass = n;
            PL:      condpass = ~n;
            VS:      condpass = v;
            VC:      condpass = ~v;
            HI:      condpass = c & ~z;
            LS:      condpass = ~c | z;
            GE:      condpass = (n == v);
            LT:      condpass = (n != v);
            GT:      condpass = ~z & (n == v);
            LE:      condpass = z | (n != v);
            AL:      condpass = 1'b1;
            default: condpass = 1'b0;   // NV: never executes
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Purpose  : Execute-stage flags register, condition gating and E->M control
//            registers. Define COND_STATS_EN to add ExecCount/SkipCount.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit
    import cond_pkg::*;
#(
    parameter int         CNT_W       = 32,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       AluFlags,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    output logic             CondExE,
    output logic             PCSrcGatedE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [3:0]       Flags
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cond_unit: CNT_W must be at least 1");
    end

    logic condpass;

    cond_check u_cond_check (
        .CondE    (CondE),
        .Flags    (Flags),
        .condpass (condpass)
    );

    assign CondExE     = condpass & ~FlushE;
    assign PCSrcGatedE = PCSrcE & CondExE;

    // Flag groups update independently; a failed or flushed instruction never writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= RESET_FLAGS;
        end else if (!StallE && CondExE) begin
            if (FlagWriteE[FW_NZ]) begin
                Flags[FLAG_N] <= AluFlags[FLAG_N];
                Flags[FLAG_Z] <= AluFlags[FLAG_Z];
            end
            if (FlagWriteE[FW_CV]) begin
                Flags[FLAG_C] <= AluFlags[FLAG_C];
                Flags[FLAG_V] <= AluFlags[FLAG_V];
            end
        end
    end

    // Stall outranks flush on the M boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else if (!StallE) begin
            if (FlushE) begin
                RegWriteM <= 1'b0;
                MemWriteM <= 1'b0;
            end else begin
                RegWriteM <= RegWriteE & CondExE;
                MemWriteM <= MemWriteE & CondExE;
            end
        end
    end

`ifdef COND_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ExecCount <= '0;
            SkipCount <= '0;
        end else if (!StallE && !FlushE) begin
            if (condpass) begin
                ExecCount <= ExecCount + CNT_W'(1);
            end else begin
                SkipCount <= SkipCount + CNT_W'(1);
            end
        end
    end
`endif

endmodule : cond_unit
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_unit
// Purpose  : Self-checking bench for cond_unit with a reference flag model and
//            an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    logic        clk;
    logic        reset;
    logic        StallE;
    logic        FlushE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic [3:0]  AluFlags;
    logic        PCSrcE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        CondExE;
    logic        PCSrcGatedE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [3:0]  Flags;
`ifdef COND_STATS_EN
    logic [31:0] ExecCount;
    logic [31:0] SkipCount;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  flags;
        logic        rw;
        logic        mw;
        logic [31:0] ec;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];

    logic [3:0]  m_flags;
    logic        m_rw;
    logic        m_mw;
    logic [31:0] m_ec;
    logic [31:0] m_sc;

    cond_unit #(
        .CNT_W       (32),
        .RESET_FLAGS (4'b0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .CondE       (CondE),
        .FlagWriteE  (FlagWriteE),
        .AluFlags    (AluFlags),
        .PCSrcE      (PCSrcE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .CondExE     (CondExE),
        .PCSrcGatedE (PCSrcGatedE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .Flags       (Flags)
`ifdef COND_STATS_EN
        ,
        .ExecCount   (ExecCount),
        .SkipCount   (SkipCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Odd codes are the complement of the preceding even code; 111x is AL/NV.
    function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n ~^ v);
            3'd6:    base = !z && (n ~^ v);
            default: base = 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    task automatic set_in(input logic rst, input logic st, input logic fl,
                          input logic [3:0] cond, input logic [1:0] fw,
                          input logic [3:0] alu, input logic pcs,
                          input logic rw, input logic mw);
        reset = rst; StallE = st; FlushE = fl; CondE = cond; FlagWriteE = fw;
        AluFlags = alu; PCSrcE = pcs; RegWriteE = rw; MemWriteE = mw;
        #1;
    endtask

    // Advance the model for the applied inputs, queue its prediction, clock the DUT.
    task automatic tick();
        exp_t e;
        logic pass, cx;
        if (reset) begin
            m_flags = 4'b0000; m_rw = 1'b0; m_mw = 1'b0; m_ec = '0; m_sc = '0;
        end else begin
            pass = ref_pass(CondE, m_flags);
            cx   = pass && !FlushE;
            if (!StallE) begin
                if (cx && FlagWriteE[1]) m_flags[3:2] = AluFlags[3:2];
                if (cx && FlagWriteE[0]) m_flags[1:0] = AluFlags[1:0];
                m_rw = FlushE ? 1'b0 : (RegWriteE && cx);
                m_mw = FlushE ? 1'b0 : (MemWriteE && cx);
                if (!FlushE) begin
                    if (pass) m_ec = m_ec + 1;
                    else      m_sc = m_sc + 1;
                end
            end
        end
        e.flags = m_flags; e.rw = m_rw; e.mw = m_mw; e.ec = m_ec; e.sc = m_sc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        set_in(1, 0, 0, 4'b1110, 2'b11, 4'b1111, 0, 1, 1);
        tick();
        e = sb.pop_front();
        checks++;
        if (Flags !== e.flags || Flags !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", Flags, e.flags);
        end
        checks++;
        if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
            errors++; $display("FAIL reset_mregs: got rw=%b mw=%b expected 0 0", RegWriteM, MemWriteM);
        end
        set_in(0, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 1, 0);
        checks++;
        if (CondExE !== 1'b0) begin
            errors++; $display("FAIL eq_after_reset: CondExE got %b expected 0", CondExE);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (RegWriteM !== e.rw || RegWriteM !== 1'b0) begin
            errors++; $display("FAIL eq_gated_rw: RegWriteM got %b expected %b", RegWriteM, e.rw);
        end
    endtask

    task automatic test_flag_latency();
        exp_t e;
        set_in(0, 0, 0, 4'b1110, 2'b11, 4'b0100, 0, 0, 0);
        tick();
        e = sb.pop_front();
        checks++;
        if (Flags !== e.flags || Flags !== 4'b0100) begin
            errors++; $display("FAIL set_z: Flags got %b expected %b", Flags, 4'b0100);
        end
        set_in(0, 0, 0, 4'b0000, 2'b00, 4'b0000, 1, 0, 1);
        checks++;
        if (CondExE !== 1'b1 || PCSrcGatedE !== 1'b1) begin
            errors++; $display("FAIL eq_branch: CondExE=%b PCSrcGatedE=%b expected 1 1", CondExE, PCSrcGatedE);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (MemWriteM !== e.mw || MemWriteM !== 1'b1) begin
            errors++; $display("FAIL eq_memwrite: MemWriteM got %b expected %b", MemWriteM, e.mw);
        end
    endtask

    task automatic test_flag_groups();
        exp_t e;
        set_in(0, 0, 0, 4'b1110, 2'b10, 4'b1011, 0, 0, 0);
        tick();
        e = sb.pop_front();
        checks++;
        if (Flags !== e.flags || Flags !== 4'b1000) begin
            errors++; $display("FAIL group_nz: Flags got %b expected %b", Flags, 4'b1000);
        end
        set_in(0, 0, 0, 4'b1110, 2'b01, 4'b0011, 0, 0, 0);
        tick();
        e = sb.pop_front();
        checks++;
        if (Flags !== e.flags || Flags !== 4'b1011) begin
            errors++; $display("FAIL group_cv: Flags got %b expected %b", Flags, 4'b1011);
        end
    endtask

    task automatic test_conditions();
        exp_t e;
        logic [3:0] gt_codes[4] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};
        logic       gt_exp[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        set_in(0, 0, 0, 4'b1110, 2'b11, 4'b1001, 0, 0, 0);
        tick();
        e = sb.pop_front();
        checks++;
        if (Flags !== e.flags) begin
            errors++; $display("FAIL load_1001: Flags got %b expected %b", Flags, e.flags);
        end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, gt_codes[i], 2'b00, 4'b0000, 0, 0, 0);
            checks++;
            if (CondExE !== gt_exp[i]) begin
                errors++; $display("FAIL signed_cond %b: CondExE got %b expected %b", gt_codes[i], CondExE, gt_exp[i]);
            end
        end
        set_in(0, 0, 0, 4'b1110, 2'b11, 4'b0110, 0, 0, 0);
        tick();
        e = sb.pop_front();
        set_in(0, 0, 0, 4'b1000, 2'b00, 4'b0000, 0, 0, 0);
        checks++;
        if (CondExE !== 1'b0) begin
            errors++; $display("FAIL hi: CondExE got %b expected 0", CondExE);
        end
        set_in(0, 0, 0, 4'b1001, 2'b00, 4'b0000, 0, 0, 0);
        checks++;
        if (CondExE !== 1'b1) begin
            errors++; $display("FAIL ls: CondExE got %b expected 1", CondExE);
        end
        set_in(0, 0, 0, 4'b1111, 2'b00, 4'b0000, 1, 1, 1);
        checks++;
        if (CondExE !== 1'b0 || PCSrcGatedE !== 1'b0) begin
            errors++; $display("FAIL nv: CondExE=%b PCSrcGatedE=%b expected 0 0", CondExE, PCSrcGatedE);
        end
        // Sweep every code against random flags versus the reference model.
        for (int k = 0; k < 16; k++) begin
            set_in(0, 0, 0, 4'b1110, 2'b11, 4'($urandom_range(0, 15)), 0, 0, 0);
            tick();
            e = sb.pop_front();
            set_in(0, 0, 0, 4'(k), 2'b00, 4'b0000, 0, 0, 0);
            checks++;
            if (CondExE !== ref_pass(4'(k), e.flags)) begin
                errors++; $display("FAIL sweep cond=%0d flags=%b: CondExE got %b expected %b",
                                   k, e.flags, CondExE, ref_pass(4'(k), e.flags));
            end
        end
    endtask

    task automatic test_stall_flush();
        exp_t e;
        logic [3:0] held;
        set_in(0, 0, 0, 4'b1110, 2'b11, 4'b0010, 0, 1, 0);
        tick();
        e = sb.pop_front();
        held = e.flags;
        set_in(0, 1, 0, 4'b1110, 2'b11, 4'b1111, 0, 0, 0);
        tick();
        e = sb.pop_front();
        checks++;
        if (Flags !== held || RegWriteM !== 1'b1 || RegWriteM !== e.rw) begin
            errors++; $display("FAIL stall_hold: Flags=%b RegWriteM=%b expected %b 1", Flags, RegWriteM, held);
        end
        set_in(0, 0, 1, 4'b1110, 2'b11, 4'b1111, 1, 1, 1);
        checks++;
        if (CondExE !== 1'b0 || PCSrcGatedE !== 1'b0) begin
            errors++; $display("FAIL flush_comb: CondExE=%b PCSrcGatedE=%b expected 0 0", CondExE, PCSrcGatedE);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || Flags !== held || Flags !== e.flags) begin
            errors++; $display("FAIL flush_bubble: rw=%b mw=%b Flags=%b expected 0 0 %b", RegWriteM, MemWriteM, Flags, held);
        end
        set_in(0, 0, 0, 4'b1110, 2'b00, 4'b0000, 0, 1, 1);
        tick();
        e = sb.pop_front();
        set_in(0, 1, 1, 4'b1110, 2'b00, 4'b0000, 0, 0, 0);
        tick();
        e = sb.pop_front();
        checks++;
        if (RegWriteM !== 1'b1 || MemWriteM !== 1'b1 || RegWriteM !== e.rw) begin
            errors++; $display("FAIL stall_over_flush: rw=%b mw=%b expected 1 1", RegWriteM, MemWriteM);
        end
    endtask

    task automatic test_reset_priority();
        exp_t e;
        set_in(0, 0, 0, 4'b1110, 2'b11, 4'b1111, 0, 0, 0);
        tick();
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0);
            tick();
            e = sb.pop_front();
        end
`ifdef COND_STATS_EN
        checks++;
        if (ExecCount !== e.ec) begin
            errors++; $display("FAIL exec_count: got %0d expected %0d", ExecCount, e.ec);
        end
`endif
        set_in(1, 1, 1, 4'b1110, 2'b11, 4'b1111, 0, 1, 1);
        tick();
        e = sb.pop_front();
        checks++;
        if (Flags !== 4'b0000 || RegWriteM !== 1'b0 || Flags !== e.flags) begin
            errors++; $display("FAIL reset_over_stall: Flags=%b rw=%b expected 0000 0", Flags, RegWriteM);
        end
`ifdef COND_STATS_EN
        checks++;
        if (ExecCount !== 32'd0 || SkipCount !== 32'd0) begin
            errors++; $display("FAIL reset_counts: exec=%0d skip=%0d expected 0 0", ExecCount, SkipCount);
        end
`endif
        set_in(0, 0, 0, 4'b0000, 2'b11, 4'b1111, 0, 1, 0);
        tick();
        e = sb.pop_front();
        checks++;
        if (Flags !== 4'b0000 || RegWriteM !== 1'b0 || Flags !== e.flags) begin
            errors++; $display("FAIL fail_no_write: Flags=%b rw=%b expected 0000 0", Flags, RegWriteM);
        end
`ifdef COND_STATS_EN
        checks++;
        if (SkipCount !== 32'd1 || ExecCount !== 32'd0 || SkipCount !== e.sc) begin
            errors++; $display("FAIL skip_count: skip=%0d exec=%0d expected 1 0", SkipCount, ExecCount);
        end
`endif
    endtask

    initial begin
        m_flags = 4'b0000; m_rw = 1'b0; m_mw = 1'b0; m_ec = '0; m_sc = '0;
        set_in(1, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_flag_latency();
        test_flag_groups();
        test_conditions();
        test_stall_flush();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cond_unit
`default_nettype wire
